// File: rtl/wdt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wdt_pkg
// Purpose  : Shared constants and types for the watchdog register front-end.
//            Holds the register offsets, the status bit positions and the
//            kick FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wdt_pkg;

  // Register byte offsets; only bits [3:2] take part in decoding.
  localparam logic [3:0] WDT_CTRL   = 4'h0;
  localparam logic [3:0] WDT_KICK   = 4'h4;
  localparam logic [3:0] WDT_CNT    = 4'h8;
  localparam logic [3:0] WDT_STATUS = 4'hC;

  // Bit positions inside the registers.
  localparam int WDT_CTRL_EN    = 0;
  localparam int WDT_KICK_GO    = 0;
  localparam int WDT_STATUS_TO   = 0;
  localparam int WDT_STATUS_BUSY = 1;

  // Kick FSM: HOLD drives the keep-alive high, GAP guarantees a low period.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } wdt_kick_e;

endpackage
`default_nettype wire

// File: rtl/wdt_sync.sv
`default_nettype none
// ============================================================================
// Module   : wdt_sync
// Purpose  : N-stage single-bit synchronizer with asynchronous reset.
//            Brings a level from a foreign clock domain into clk.
// Ports    : clk  - destination clock
//            rst  - asynchronous active-high reset (all stages cleared)
//            i_d  - asynchronous input level
//            o_q  - synchronized level, STAGES cycles behind i_d
// Revision : 1.0 - initial release
// ============================================================================
module wdt_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/wdt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wdt_ctrl
// Purpose  : CPU-side register front-end of the watchdog timer. Provides
//            CTRL/KICK/CNT/STATUS registers, drives WDEN/WDLIVE/WTOCNT and
//            turns the asynchronous WTO timeout into sticky status, a level
//            interrupt and a one-cycle reset request.
// Ports    : clk, rst            - system clock, async active-high reset
//            reg_sel/we/addr/wdata - single-cycle register access
//            reg_rdata/reg_rvalid  - read data, valid one cycle after a read
//            WDEN, WDLIVE, WTOCNT  - control outputs to the timer
//            WTO                   - timeout from the timer (asynchronous)
//            wdt_irq, wdt_rst_req  - interrupt level, reset request pulse
// Revision : 1.0 - initial release
// ============================================================================
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int LIVE_HOLD   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  input  logic        WTO,
  output logic        wdt_irq,
  output logic        wdt_rst_req
);

  localparam logic [7:0] c_HOLD_LOAD = 8'(LIVE_HOLD - 1);

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic w_wr, w_rd;
  logic w_sel_ctrl, w_sel_kick, w_sel_cnt, w_sel_stat;
  logic w_unused_addr;

  assign w_wr       = reg_sel & reg_we;
  assign w_rd       = reg_sel & ~reg_we;
  assign w_sel_ctrl = (reg_addr[3:2] == WDT_CTRL[3:2]);
  assign w_sel_kick = (reg_addr[3:2] == WDT_KICK[3:2]);
  assign w_sel_cnt  = (reg_addr[3:2] == WDT_CNT[3:2]);
  assign w_sel_stat = (reg_addr[3:2] == WDT_STATUS[3:2]);
  // Byte lanes inside a word are not decoded.
  assign w_unused_addr = ^reg_addr[1:0];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic        r_en;
  logic [31:0] r_cnt;
  logic        r_to;
  logic        r_wto_d;
  logic        r_rst_req;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  wdt_kick_e   r_state;
  logic [7:0]  r_hold;

  logic        w_en_nxt;
  logic        w_kick;
  logic        w_busy;
  logic        w_wto_s;
  logic        w_wto_rise;
  logic [31:0] w_rdata_nxt;
  wdt_kick_e   w_state_nxt;
  logic [7:0]  w_hold_nxt;

  // EN as it will be next cycle; lets a CTRL write that clears EN abort a
  // kick in the very next cycle rather than one cycle later.
  assign w_en_nxt = (w_wr && w_sel_ctrl) ? reg_wdata[WDT_CTRL_EN] : r_en;
  assign w_busy   = (r_state != IDLE);
  assign w_kick   = w_wr && w_sel_kick && reg_wdata[WDT_KICK_GO] && r_en && !w_busy;

  // --------------------------------------------------------------------------
  // Timeout synchronizer and rising-edge detect
  // --------------------------------------------------------------------------
  wdt_sync #(
    .STAGES (SYNC_STAGES)
  ) u_wto_sync (
    .clk (clk),
    .rst (rst),
    .i_d (WTO),
    .o_q (w_wto_s)
  );

  assign w_wto_rise = w_wto_s & ~r_wto_d;

  // --------------------------------------------------------------------------
  // Read mux (values before any same-cycle update)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata_nxt = '0;
    if (w_rd) begin
      if (w_sel_ctrl) begin
        w_rdata_nxt[WDT_CTRL_EN] = r_en;
      end else if (w_sel_cnt) begin
        w_rdata_nxt = r_cnt;
      end else if (w_sel_stat) begin
        w_rdata_nxt[WDT_STATUS_TO]   = r_to;
        w_rdata_nxt[WDT_STATUS_BUSY] = w_busy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_cnt     <= '0;
      r_to      <= 1'b0;
      r_wto_d   <= 1'b0;
      r_rst_req <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_en <= w_en_nxt;
      // The reload count is frozen while the watchdog runs.
      if (w_wr && w_sel_cnt && !r_en) begin
        r_cnt <= reg_wdata;
      end
      // A new timeout edge beats a simultaneous write-1-to-clear.
      if (w_wto_rise) begin
        r_to <= 1'b1;
      end else if (w_wr && w_sel_stat && reg_wdata[WDT_STATUS_TO]) begin
        r_to <= 1'b0;
      end
      r_rst_req <= w_wto_rise & r_en;
      r_wto_d   <= w_wto_s;
      r_rdata   <= w_rdata_nxt;
      r_rvalid  <= w_rd;
    end
  end

  // --------------------------------------------------------------------------
  // Kick FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_kick) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = c_HOLD_LOAD;
        end
      end
      HOLD: begin
        if (r_hold == 8'd0) begin
          w_state_nxt = GAP;
          w_hold_nxt  = c_HOLD_LOAD;
        end else begin
          w_hold_nxt = r_hold - 8'd1;
        end
      end
      GAP: begin
        if (r_hold == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_hold_nxt = r_hold - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
    // Disabling the watchdog abandons any kick in progress.
    if (!w_en_nxt) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign WDEN        = r_en;
  assign WDLIVE      = (r_state == HOLD);
  assign WTOCNT      = r_cnt;
  assign wdt_irq     = r_to;
  assign wdt_rst_req = r_rst_req;
  assign reg_rdata   = r_rdata;
  assign reg_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_wdt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wdt_ctrl
// Purpose  : Self-checking bench for wdt_ctrl. A timestamp-based reference
//            model (kick start time, WTO sample history) predicts every
//            output each cycle; directed sequences pin key cycles with
//            literal values, then randomized traffic runs against the model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdt_ctrl;

  localparam int L = 8;
  localparam int N = 2;
  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_KICK = 4'h4;
  localparam logic [3:0] A_CNT  = 4'h8;
  localparam logic [3:0] A_STAT = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_sel = 1'b0;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic        WTO = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        WDEN;
  logic        WDLIVE;
  logic [31:0] WTOCNT;
  logic        wdt_irq;
  logic        wdt_rst_req;

  wdt_ctrl #(
    .LIVE_HOLD   (L),
    .SYNC_STAGES (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_sel     (reg_sel),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .reg_rvalid  (reg_rvalid),
    .WDEN        (WDEN),
    .WDLIVE      (WDLIVE),
    .WTOCNT      (WTOCNT),
    .WTO         (WTO),
    .wdt_irq     (wdt_irq),
    .wdt_rst_req (wdt_rst_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: everything derived from cycle timestamps.
  // --------------------------------------------------------------------------
  bit          hist [0:8191];
  int          cyc = 0;
  int          hist_floor = 0;
  logic        m_en = 1'b0;
  logic        m_to = 1'b0;
  logic        m_rstreq = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  bit          k_valid = 1'b0;
  int          ks = 0;
  int          mc = 0;
  bit          m_rise = 1'b0;
  bit          m_en_old = 1'b0;
  bit          m_bsy = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_rd = 1'b0;
  logic [1:0]  m_idx = 2'd0;

  function automatic bit busy_at(input int c);
    return k_valid && (c >= ks + 1) && (c <= ks + 2 * L);
  endfunction

  function automatic bit live_at(input int c);
    return k_valid && (c >= ks + 1) && (c <= ks + L);
  endfunction

  // WTO level seen at the edge ending cycle i; zero before the last reset.
  function automatic bit h(input int i);
    return (i < hist_floor) ? 1'b0 : hist[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 1'b0; m_to = 1'b0; m_rstreq = 1'b0; m_rvalid = 1'b0;
      m_cnt = 32'h0; m_rdata = 32'h0; k_valid = 1'b0;
      hist_floor = cyc;
    end else begin
      mc = cyc;
      if (mc < 8192) hist[mc] = WTO;
      m_en_old = m_en;
      m_bsy    = busy_at(mc);
      // Synchronized WTO rises in cycle c when WTO was 0 then 1 at the
      // edges ending cycles c-N-1 and c-N.
      m_rise   = h(mc - N) && !h(mc - N - 1);
      m_wr     = reg_sel && reg_we;
      m_rd     = reg_sel && !reg_we;
      m_idx    = reg_addr[3:2];
      m_rvalid = m_rd;
      m_rdata  = 32'h0;
      if (m_rd) begin
        case (m_idx)
          2'd0:    m_rdata = {31'h0, m_en};
          2'd2:    m_rdata = m_cnt;
          2'd3:    m_rdata = {30'h0, m_bsy, m_to};
          default: m_rdata = 32'h0;
        endcase
      end
      if (m_wr && m_idx == 2'd0) begin
        m_en = reg_wdata[0];
        if (!m_en) k_valid = 1'b0;
      end
      if (m_wr && m_idx == 2'd1 && reg_wdata[0] && m_en_old && !m_bsy) begin
        k_valid = 1'b1;
        ks = mc;
      end
      if (m_wr && m_idx == 2'd2 && !m_en_old) m_cnt = reg_wdata;
      m_rstreq = m_rise && m_en_old;
      if (m_rise) m_to = 1'b1;
      else if (m_wr && m_idx == 2'd3 && reg_wdata[0]) m_to = 1'b0;
      cyc = mc + 1;
    end
  end

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_WDEN",    32'(WDEN),        32'(m_en));
      chk("cmp_WDLIVE",  32'(WDLIVE),      32'(live_at(cyc)));
      chk("cmp_WTOCNT",  WTOCNT,           m_cnt);
      chk("cmp_irq",     32'(wdt_irq),     32'(m_to));
      chk("cmp_rst_req", 32'(wdt_rst_req), 32'(m_rstreq));
      chk("cmp_rvalid",  32'(reg_rvalid),  32'(m_rvalid));
      chk("cmp_rdata",   reg_rdata,        m_rdata);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (entered and left #1 after a rising edge)
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic acc(input bit we, input logic [3:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_we = we; reg_addr = a; reg_wdata = d;
    tick(1);
    reg_sel = 1'b0; reg_we = 1'b0; reg_addr = 4'h0; reg_wdata = 32'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    acc(1'b1, a, d);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    acc(1'b0, a, 32'h0);
    chk(nm, reg_rdata, exp);
  endtask

  logic [31:0] rnd_d;
  logic [3:0]  rnd_a;
  int          rnd_r;

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_WDEN",   32'(WDEN),        32'h0);
    chk("reset_WDLIVE", 32'(WDLIVE),      32'h0);
    chk("reset_WTOCNT", WTOCNT,           32'h0);
    chk("reset_irq",    32'(wdt_irq),     32'h0);
    chk("reset_rstreq", 32'(wdt_rst_req), 32'h0);
    chk("reset_rvalid", 32'(reg_rvalid),  32'h0);
    rst = 1'b0;
    run_cmp = 1'b1;
    tick(2);

    // Count lock
    wr(A_CNT, 32'h1000);
    chk("cnt_out", WTOCNT, 32'h1000);
    wr(A_CTRL, 32'h1);
    wr(A_CNT, 32'h20);
    rd_chk("cnt_locked", A_CNT, 32'h1000);
    wr(A_CTRL, 32'h0);
    wr(A_CNT, 32'h20);
    rd_chk("cnt_unlocked", A_CNT, 32'h20);

    // Kick sequence: kick at t, cycle t+k handled in iteration k
    wr(A_CTRL, 32'h1);
    wr(A_KICK, 32'h1);
    for (int k = 1; k <= 18; k++) begin
      if (k <= 17) chk("kick_live", 32'(WDLIVE), 32'(k <= 8));
      if (k == 11) chk("kick_status_busy", reg_rdata, 32'h2);
      if (k == 18) chk("kick_status_idle", reg_rdata, 32'h0);
      if (k == 5) begin
        reg_sel = 1'b1; reg_we = 1'b1; reg_addr = A_KICK; reg_wdata = 32'h1;
      end else if (k == 10 || k == 17) begin
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = A_STAT; reg_wdata = 32'h0;
      end
      tick(1);
      reg_sel = 1'b0; reg_we = 1'b0; reg_addr = 4'h0; reg_wdata = 32'h0;
    end

    // EN cleared during HOLD
    wr(A_KICK, 32'h1);
    tick(1);
    wr(A_CTRL, 32'h0);
    chk("abort_live", 32'(WDLIVE), 32'h0);
    rd_chk("abort_status", A_STAT, 32'h0);
    wr(A_KICK, 32'h1);
    chk("kick_disabled_live", 32'(WDLIVE), 32'h0);
    rd_chk("kick_disabled_status", A_STAT, 32'h0);

    // Timeout with EN=1
    wr(A_CTRL, 32'h1);
    WTO = 1'b1;
    tick(N);
    chk("to_not_yet", 32'(wdt_irq), 32'h0);
    tick(1);
    chk("to_irq", 32'(wdt_irq), 32'h1);
    chk("to_rst_req", 32'(wdt_rst_req), 32'h1);
    tick(1);
    chk("to_rst_req_one", 32'(wdt_rst_req), 32'h0);
    rd_chk("to_status", A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    chk("to_cleared", 32'(wdt_irq), 32'h0);
    tick(5);
    chk("to_no_reset_level", 32'(wdt_irq), 32'h0);
    WTO = 1'b0;
    tick(4);
    WTO = 1'b1;
    tick(N + 1);
    chk("to_reedge", 32'(wdt_irq), 32'h1);

    // Set beats simultaneous clear
    WTO = 1'b0;
    tick(4);
    WTO = 1'b1;
    tick(N);
    wr(A_STAT, 32'h1);
    chk("set_wins", 32'(wdt_irq), 32'h1);
    chk("set_wins_req", 32'(wdt_rst_req), 32'h1);

    // Timeout with EN=0: status only
    wr(A_CTRL, 32'h0);
    WTO = 1'b0;
    wr(A_STAT, 32'h1);
    tick(4);
    chk("dis_cleared", 32'(wdt_irq), 32'h0);
    WTO = 1'b1;
    tick(N + 1);
    chk("dis_irq", 32'(wdt_irq), 32'h1);
    chk("dis_no_req", 32'(wdt_rst_req), 32'h0);
    WTO = 1'b0;

    // Reset mid-kick
    wr(A_CNT, 32'h55);
    wr(A_CTRL, 32'h1);
    wr(A_KICK, 32'h1);
    tick(3);
    chk("pre_reset_live", 32'(WDLIVE), 32'h1);
    rst = 1'b1;
    #1;
    chk("reset_live_async", 32'(WDLIVE), 32'h0);
    chk("reset_en_async", 32'(WDEN), 32'h0);
    chk("reset_cnt_async", WTOCNT, 32'h0);
    chk("reset_irq_async", 32'(wdt_irq), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    rd_chk("reset_rd_ctrl", A_CTRL, 32'h0);
    rd_chk("reset_rd_cnt", A_CNT, 32'h0);
    rd_chk("reset_rd_status", A_STAT, 32'h0);
    rd_chk("reset_rd_kick", A_KICK, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) WTO = ~WTO;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      rnd_r = int'($urandom_range(0, 9));
      if (rnd_r < 4) begin
        tick(1);
      end else begin
        rnd_a = 4'($urandom_range(0, 15));
        rnd_d = $urandom;
        if ($urandom_range(0, 2) != 0) rnd_d[0] = 1'b1;
        acc(rnd_r < 8, rnd_a, rnd_d);
      end
    end
    tick(2);
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
